// File: rtl/aes_pkg.sv
// Shared AES constants and types: forward S-box, Rcon table,
// key-schedule state enum and the AES-128 round count.
package aes_pkg;

    localparam int AES128_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ks_state_t;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Rcon for the round whose key is being undone (1..10)
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub
);

    assign sub = SBOX[data];

endmodule

// File: rtl/inv_key_gen.sv
// Reverse AES-128 key schedule: walks from the round-NR key
// back to the cipher key, one round key per enabled clock.
module inv_key_gen
    import aes_pkg::*;
#(
    parameter int KEY_LENGTH = 128,
    parameter int NR         = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [KEY_LENGTH-1:0] L_KEY,
    input  logic                  Load,
    input  logic                  En,
    output logic [KEY_LENGTH-1:0] subKey_curr,
    output logic [3:0]            Round,
    output logic                  Key_Vld,
    output logic                  Done
);

    ks_state_t             state;
    ks_state_t             state_n;
    logic [KEY_LENGTH-1:0] key_n;
    logic [3:0]            round_n;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot;
    logic [31:0] sw;

    assign w0 = subKey_curr[127:96];
    assign w1 = subKey_curr[95:64];
    assign w2 = subKey_curr[63:32];
    assign w3 = subKey_curr[31:0];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    assign rot = {p3[23:0], p3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .data (rot[8*i +: 8]),
            .sub  (sw[8*i +: 8])
        );
    end

    assign p0 = w0 ^ sw ^ {rcon(Round), 24'h0};

    always_comb begin
        state_n = state;
        key_n   = subKey_curr;
        round_n = Round;
        if (Load) begin
            key_n   = L_KEY;
            round_n = 4'(NR);
            state_n = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (En) begin
                        key_n   = {p0, p1, p2, p3};
                        round_n = Round - 4'd1;
                        if (Round == 4'd1) begin
                            state_n = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            subKey_curr <= '0;
            Round       <= '0;
        end else begin
            state       <= state_n;
            subKey_curr <= key_n;
            Round       <= round_n;
        end
    end

    // DONE implies Round==0, so both flags decode from state alone
    assign Key_Vld = (state != IDLE);
    assign Done    = (state == DONE);

endmodule

// File: tb/tb_inv_key_gen.sv
// Directed bench for inv_key_gen using the FIPS-197 A.1
// key schedule as reference round keys.
module tb_inv_key_gen;

    logic         CLK = 1'b0;
    logic         RST;
    logic [127:0] L_KEY;
    logic         Load;
    logic         En;
    logic [127:0] subKey_curr;
    logic [3:0]   Round;
    logic         Key_Vld;
    logic         Done;

    int errors = 0;
    int checks = 0;

    logic [127:0] keys [11];

    inv_key_gen #(.KEY_LENGTH(128), .NR(10)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .L_KEY       (L_KEY),
        .Load        (Load),
        .En          (En),
        .subKey_curr (subKey_curr),
        .Round       (Round),
        .Key_Vld     (Key_Vld),
        .Done        (Done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load();
        L_KEY = keys[10];
        Load  = 1'b1;
        tick();
        Load  = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; Load = 1'b0; En = 1'b0; L_KEY = '0;
        tick();
        tick();
        checks++;
        if (subKey_curr !== '0 || Round !== 4'd0 ||
            Key_Vld !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset: key=%h rnd=%0d vld=%b done=%b want 0",
                     subKey_curr, Round, Key_Vld, Done);
        end
        RST = 1'b0;
        tick();
        checks++;
        if (Key_Vld !== 1'b0) begin
            errors++;
            $display("FAIL idle_vld: got %b want 0", Key_Vld);
        end
    endtask

    task automatic test_walk();
        do_load();
        checks++;
        if (subKey_curr !== keys[10] || Round !== 4'd10 ||
            Key_Vld !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL load: key=%h rnd=%0d vld=%b done=%b want %h 10 1 0",
                     subKey_curr, Round, Key_Vld, Done, keys[10]);
        end
        En = 1'b1;
        for (int r = 9; r >= 0; r--) begin
            tick();
            checks++;
            if (subKey_curr !== keys[r] || Round !== 4'(r) ||
                Key_Vld !== 1'b1 || Done !== (r == 0)) begin
                errors++;
                $display("FAIL walk_r%0d: key=%h rnd=%0d vld=%b done=%b want %h",
                         r, subKey_curr, Round, Key_Vld, Done, keys[r]);
            end
        end
        En = 1'b0;
    endtask

    task automatic test_done_hold();
        En = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (subKey_curr !== keys[0] || Round !== 4'd0 || Done !== 1'b1) begin
                errors++;
                $display("FAIL done_hold: key=%h rnd=%0d done=%b want %h 0 1",
                         subKey_curr, Round, Done, keys[0]);
            end
        end
        En = 1'b0;
    endtask

    task automatic test_gaps();
        int exp_r;
        do_load();
        exp_r = 10;
        for (int c = 0; c < 100 && exp_r > 0; c++) begin
            En = 1'($urandom_range(0, 1));
            tick();
            if (En) exp_r--;
            checks++;
            if (subKey_curr !== keys[exp_r] || Round !== 4'(exp_r)) begin
                errors++;
                $display("FAIL gaps_c%0d: key=%h rnd=%0d want %h %0d",
                         c, subKey_curr, Round, keys[exp_r], exp_r);
            end
        end
        En = 1'b0;
        checks++;
        if (Done !== 1'b1 || Round !== 4'd0) begin
            errors++;
            $display("FAIL gaps_end: done=%b rnd=%0d want 1 0", Done, Round);
        end
    endtask

    task automatic test_load_en();
        L_KEY = keys[10]; Load = 1'b1; En = 1'b1;
        tick();
        Load = 1'b0; En = 1'b0;
        checks++;
        if (subKey_curr !== keys[10] || Round !== 4'd10 || Done !== 1'b0) begin
            errors++;
            $display("FAIL load_en: key=%h rnd=%0d done=%b want %h 10 0",
                     subKey_curr, Round, Done, keys[10]);
        end
    endtask

    task automatic test_restart();
        En = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        En = 1'b0;
        checks++;
        if (Round !== 4'd5 || subKey_curr !== keys[5]) begin
            errors++;
            $display("FAIL pre_restart: rnd=%0d key=%h want 5 %h",
                     Round, subKey_curr, keys[5]);
        end
        do_load();
        checks++;
        if (Round !== 4'd10 || Done !== 1'b0 || subKey_curr !== keys[10]) begin
            errors++;
            $display("FAIL restart: rnd=%0d done=%b key=%h want 10 0 %h",
                     Round, Done, subKey_curr, keys[10]);
        end
        En = 1'b1;
        for (int r = 9; r >= 0; r--) begin
            tick();
            checks++;
            if (subKey_curr !== keys[r] || Round !== 4'(r)) begin
                errors++;
                $display("FAIL rewalk_r%0d: key=%h rnd=%0d want %h",
                         r, subKey_curr, Round, keys[r]);
            end
        end
        En = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_load();
        En = 1'b1;
        tick();
        tick();
        En = 1'b0;
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if (subKey_curr !== '0 || Round !== 4'd0 ||
            Key_Vld !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: key=%h rnd=%0d vld=%b done=%b want 0",
                     subKey_curr, Round, Key_Vld, Done);
        end
        L_KEY = keys[10];
        Load  = 1'b1;
        tick();
        checks++;
        if (subKey_curr !== '0 || Round !== 4'd0 || Key_Vld !== 1'b0) begin
            errors++;
            $display("FAIL load_in_rst: key=%h rnd=%0d vld=%b want 0",
                     subKey_curr, Round, Key_Vld);
        end
        Load = 1'b0;
        RST  = 1'b0;
        tick();
    endtask

    initial begin
        keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

        test_reset();
        test_walk();
        test_done_hold();
        test_gaps();
        test_load_en();
        test_restart();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
